// File: rtl/wallace_three_bit_divider_if.sv
// Handshake bundle for the restoring divider: operand side (in_*) and result side (out_*).
interface wallace_three_bit_divider_if #(
   parameter int DW = 6,
   parameter int VW = 3
);
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in1;
   logic [VW-1:0] in2;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] quot;
   logic [VW-1:0] rem;
   logic          div_zero;

   modport master (
      output in_valid, in1, in2, out_ready,
      input  in_ready, out_valid, quot, rem, div_zero
   );

   modport slave (
      input  in_valid, in1, in2, out_ready,
      output in_ready, out_valid, quot, rem, div_zero
   );
endinterface

// File: rtl/wallace_three_bit_divider.sv
// Sequential restoring divider, one quotient bit per clock, valid/ready on both sides.
// WALLACE_DIV_ZERO_FLAG_EN: short-circuit a zero divisor and raise div_zero.
module wallace_three_bit_divider #(
   parameter int DW = 6,
   parameter int VW = 3
) (
   input logic                      clk,
   input logic                      rst,
   wallace_three_bit_divider_if.slave bus
);
   localparam int CW = (DW > 1) ? $clog2(DW) : 1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t        state, state_nxt;
   logic [DW-1:0] dvd;
   logic [VW-1:0] dvs;
   logic [VW:0]   pr;
   logic [CW-1:0] cnt;
   logic [DW-1:0] quot_q;
   logic [VW-1:0] rem_q;

   logic          accept;
   logic          finish;
   logic [VW:0]   t;
   logic          ge;
   logic [VW:0]   pr_nxt;
   logic [DW-1:0] dvd_nxt;
   logic          in_ready_c;
   logic          out_valid_c;

`ifdef WALLACE_DIV_ZERO_FLAG_EN
   logic zpend;
   logic dz_q;
   assign finish = zpend || (cnt == '0);
`else
   assign finish = (cnt == '0);
`endif

   assign accept = bus.in_valid && (state == IDLE);

   // The dividend register doubles as the quotient register: bits leave at the
   // top as quotient bits enter at the bottom.
   always_comb begin
      t       = {pr[VW-1:0], dvd[DW-1]};
      ge      = (t >= {1'b0, dvs});
      pr_nxt  = ge ? (t - {1'b0, dvs}) : t;
      dvd_nxt = {dvd[DW-2:0], ge};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = CALC;
         CALC:    if (finish) state_nxt = DONE;
         DONE:    if (bus.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready_c  = (state == IDLE);
      out_valid_c = (state == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dvd    <= '0;
         dvs    <= '0;
         pr     <= '0;
         cnt    <= '0;
         quot_q <= '0;
         rem_q  <= '0;
`ifdef WALLACE_DIV_ZERO_FLAG_EN
         zpend  <= 1'b0;
         dz_q   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (accept) begin
               dvd   <= bus.in1;
               dvs   <= bus.in2;
               pr    <= '0;
               cnt   <= CW'(DW - 1);
`ifdef WALLACE_DIV_ZERO_FLAG_EN
               zpend <= (bus.in2 == '0);
`endif
            end
            CALC: begin
               dvd <= dvd_nxt;
               pr  <= pr_nxt;
               if (!finish) cnt <= cnt - 1'b1;
`ifdef WALLACE_DIV_ZERO_FLAG_EN
               if (zpend) begin
                  zpend  <= 1'b0;
                  quot_q <= '1;
                  rem_q  <= '0;
                  dz_q   <= 1'b1;
               end else if (finish) begin
                  quot_q <= dvd_nxt;
                  rem_q  <= pr_nxt[VW-1:0];
               end
`else
               if (finish) begin
                  quot_q <= dvd_nxt;
                  rem_q  <= pr_nxt[VW-1:0];
               end
`endif
            end
            DONE: begin
`ifdef WALLACE_DIV_ZERO_FLAG_EN
               if (bus.out_ready) dz_q <= 1'b0;
`endif
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.quot      = quot_q;
   assign bus.rem       = rem_q;
`ifdef WALLACE_DIV_ZERO_FLAG_EN
   assign bus.div_zero  = dz_q;
`else
   assign bus.div_zero  = 1'b0;
`endif
endmodule

// File: tb/tb_wallace_three_bit_divider.sv
// Scoreboard bench for the restoring divider: driver queues expected results, monitor checks them.
module tb_wallace_three_bit_divider;
   localparam int DW = 6;
   localparam int VW = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   wallace_three_bit_divider_if #(.DW(DW), .VW(VW)) bus();
   wallace_three_bit_divider #(.DW(DW), .VW(VW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

   typedef struct {
      int q;
      int r;
      int dz;
      int acc;
      int lat;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   bit   rnd_on = 1'b0;
   bit   seen = 1'b0;
   bit   chk_ir = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference: plain integer division; a zero divisor follows the configured rule.
   function automatic exp_t model(input int a, input int b);
      exp_t e;
      e.acc = 0;
      if (b == 0) begin
         e.q = (1 << DW) - 1;
`ifdef WALLACE_DIV_ZERO_FLAG_EN
         e.r = 0; e.dz = 1; e.lat = 1;
`else
         e.r = a % (1 << VW); e.dz = 0; e.lat = DW;
`endif
      end else begin
         e.q = a / b; e.r = a % b; e.dz = 0; e.lat = DW;
      end
      return e;
   endfunction

   task automatic issue(input int a, input int b);
      int   n = 0;
      exp_t e;
      @(negedge clk);
      while (!bus.in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) begin
         chk("issue_timeout", 0, 1);
         return;
      end
      e = model(a, b);
      e.acc = cyc + 1;
      sb.push_back(e);
      bus.in_valid = 1'b1;
      bus.in1 = a[DW-1:0];
      bus.in2 = b[VW-1:0];
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in1 = DW'($urandom);
      bus.in2 = VW'($urandom);
   endtask

   task automatic set_ready(input logic v);
      @(posedge clk);
      #1 bus.out_ready = v;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("drain", sb.size(), 0);
   endtask

   task automatic chk_reset_outs(input string nm);
      chk({nm, "_in_ready"}, bus.in_ready, 1);
      chk({nm, "_out_valid"}, bus.out_valid, 0);
      chk({nm, "_quot"}, bus.quot, 0);
      chk({nm, "_rem"}, bus.rem, 0);
      chk({nm, "_div_zero"}, bus.div_zero, 0);
   endtask

   // Monitor: latency on first sight of out_valid, data at the handshake.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         seen   = 1'b0;
         chk_ir = 1'b0;
      end else begin
         if (chk_ir) begin
            chk("in_ready_after_hs", bus.in_ready, 1);
            chk("out_valid_after_hs", bus.out_valid, 0);
            chk_ir = 1'b0;
         end else if (bus.out_valid) begin
            if (sb.size() == 0) begin
               chk("unexpected_out_valid", 1, 0);
            end else begin
               if (!seen) begin
                  chk("latency", cyc - sb[0].acc, sb[0].lat);
                  seen = 1'b1;
               end
               if (bus.out_ready) begin
                  e = sb.pop_front();
                  chk("quot", bus.quot, e.q);
                  chk("rem", bus.rem, e.r);
                  chk("div_zero", bus.div_zero, e.dz);
                  seen   = 1'b0;
                  chk_ir = 1'b1;
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.in1       = '0;
      bus.in2       = '0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk_reset_outs("reset");

      issue(42, 5);
      issue(63, 1);
      issue(0, 3);
      issue(49, 7);
      issue(5, 7);
      drain();

      // Backpressure: result must hold, new operands must be ignored.
      set_ready(1'b0);
      issue(35, 6);
      begin
         int n = 0;
         while (!bus.out_valid && n < 50) begin
            @(negedge clk);
            n++;
         end
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_out_valid", bus.out_valid, 1);
         chk("bp_quot", bus.quot, 5);
         chk("bp_rem", bus.rem, 5);
         bus.in_valid = 1'b1;
         bus.in1 = DW'($urandom);
         bus.in2 = VW'($urandom_range(1, 7));
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      set_ready(1'b1);
      drain();
      repeat (DW + 3) @(negedge clk);

      // Abort mid-calculation.
      issue(20, 3);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      #1 chk_reset_outs("abort");
      void'(sb.pop_back());
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < DW + 2; i++) begin
         @(negedge clk);
         chk("abort_no_out", bus.out_valid, 0);
      end
      issue(20, 3);
      issue(9, 0);
      drain();

      for (int a = 0; a < 64; a++)
         for (int b = 1; b < 8; b++)
            issue(a, b);
      drain();

      rnd_on = 1'b1;
      fork
         begin
            repeat (150) issue($urandom_range(0, 63), $urandom_range(0, 7));
            rnd_on = 1'b0;
         end
         begin
            while (rnd_on) set_ready(1'($urandom_range(0, 1)));
         end
      join
      set_ready(1'b1);
      drain();
      repeat (DW + 3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
